accel_spi_sequencer: RTL and testbench

- Transaction sequencer that sits directly upstream of the SPI serializer/deserializer and drives its start / data_tx / done / data_rx handshake.
- After reset it writes a fixed accelerometer init table (3 register writes).
- It then periodically reads the six data registers 0x32..0x37 and publishes signed 16-bit X/Y/Z samples with a one-cycle valid pulse.
- A watchdog re-runs init if the serializer never returns done.

---
 rtl/accel_seq_pkg.sv | 26 ++
 rtl/accel_poll_timer.sv | 26 ++
 rtl/accel_spi_sequencer.sv | 167 ++++++++++++++++
 tb/tb_accel_spi_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/accel_seq_pkg.sv
// Shared types, constants and command-word helper for the accelerometer SPI sequencer.
package accel_seq_pkg;

   typedef enum logic [2:0] {
      ST_RST,
      ST_INIT_ISSUE,
      ST_INIT_WAIT,
      ST_POLL_WAIT,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_PUBLISH
   } seq_state_t;

   localparam int INIT_LEN = 3;

   // Entry 0 is written first: DATA_FORMAT, then BW_RATE, then POWER_CTL.
   localparam logic [INIT_LEN-1:0][15:0] INIT_TABLE = {16'h2D08, 16'h2C0A, 16'h3108};

   localparam logic [5:0] DATA_BASE_ADDR = 6'h32;
   localparam int         DATA_BYTES     = 6;

   function automatic logic [15:0] make_cmd(input logic rd, input logic [5:0] addr, input logic [7:0] data);
      return {rd, 1'b0, addr, data};
   endfunction

endpackage

// File: rtl/accel_poll_timer.sv
// Reloadable down-counter that paces the gap between sample bursts.
module accel_poll_timer #(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] RELOAD = '0
) (
   input  logic spi_clk,
   input  logic reset_n,
   input  logic load,
   output logic zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= RELOAD;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/accel_spi_sequencer.sv
// Drives the SPI serializer handshake: writes the init table, then polls the six
// data registers and publishes X/Y/Z, with a watchdog that re-runs init on a stall.
module accel_spi_sequencer
   import accel_seq_pkg::*;
#(
   parameter int POLL_CYCLES    = 1000,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        spi_clk,
   input  logic        reset_n,
   output logic        spi_start,
   output logic [15:0] spi_data_tx,
   input  logic        spi_done,
   input  logic [7:0]  spi_data_rx,
   output logic [15:0] x_data,
   output logic [15:0] y_data,
   output logic [15:0] z_data,
   output logic        data_valid,
   output logic        init_done,
   output logic        fault
);

   localparam int MAX_CYCLES = (POLL_CYCLES > TIMEOUT_CYCLES) ? POLL_CYCLES : TIMEOUT_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   // PUBLISH is the first cycle of the poll interval, so the wait itself is one shorter.
   localparam int              POLL_RELOAD  = (POLL_CYCLES > 1) ? POLL_CYCLES - 2 : 0;
   localparam logic [CW-1:0]   TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]      LAST_INIT    = 2'(INIT_LEN - 1);
   localparam logic [2:0]      LAST_BYTE    = 3'(DATA_BYTES - 1);

   seq_state_t      state;
   seq_state_t      next_state;
   logic [1:0]      idx;
   logic [2:0]      byte_idx;
   logic [CW-1:0]   wd_count;
   logic [15:0]     tx_hold;
   logic [15:0]     issue_cmd;
   logic [7:0]      shadow [DATA_BYTES-1];
   logic            in_issue;
   logic            in_wait;
   logic            wd_expire;
   logic            fault_set;
   logic            poll_load;
   logic            poll_zero;

   accel_poll_timer #(
      .WIDTH  (CW),
      .RELOAD (CW'(POLL_RELOAD))
   ) u_poll_timer (
      .spi_clk (spi_clk),
      .reset_n (reset_n),
      .load    (poll_load),
      .zero    (poll_zero)
   );

   assign wd_expire = (wd_count == TIMEOUT_LAST);

   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_RST;
      end else begin
         state <= next_state;
      end
   end

   // A done arriving in the same cycle as the timeout takes priority over the fault.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_RST:        next_state = ST_INIT_ISSUE;
         ST_INIT_ISSUE: next_state = ST_INIT_WAIT;
         ST_INIT_WAIT: begin
            if (spi_done) begin
               next_state = (idx == LAST_INIT) ? ST_POLL_WAIT : ST_INIT_ISSUE;
            end else if (wd_expire) begin
               next_state = ST_RST;
            end
         end
         ST_POLL_WAIT: begin
            if (poll_zero) begin
               next_state = ST_RD_ISSUE;
            end
         end
         ST_RD_ISSUE:   next_state = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (spi_done) begin
               next_state = (byte_idx == LAST_BYTE) ? ST_PUBLISH : ST_RD_ISSUE;
            end else if (wd_expire) begin
               next_state = ST_RST;
            end
         end
         ST_PUBLISH:    next_state = ST_POLL_WAIT;
         default:       next_state = ST_RST;
      endcase
   end

   always_comb begin
      in_issue    = (state == ST_INIT_ISSUE) || (state == ST_RD_ISSUE);
      in_wait     = (state == ST_INIT_WAIT) || (state == ST_RD_WAIT);
      spi_start   = in_issue;
      data_valid  = (state == ST_PUBLISH);
      poll_load   = (next_state == ST_POLL_WAIT) && (state != ST_POLL_WAIT);
      fault_set   = in_wait && !spi_done && wd_expire;
      issue_cmd   = (state == ST_INIT_ISSUE) ? INIT_TABLE[idx]
                                             : make_cmd(1'b1, DATA_BASE_ADDR + 6'(byte_idx), 8'h00);
      spi_data_tx = in_issue ? issue_cmd : tx_hold;
   end

   // The sixth byte goes straight to the outputs so x/y/z line up with the data_valid pulse.
   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         idx       <= '0;
         byte_idx  <= '0;
         wd_count  <= '0;
         tx_hold   <= '0;
         x_data    <= '0;
         y_data    <= '0;
         z_data    <= '0;
         init_done <= 1'b0;
         fault     <= 1'b0;
         for (int i = 0; i < DATA_BYTES - 1; i++) begin
            shadow[i] <= '0;
         end
      end else begin
         if (in_issue) begin
            tx_hold  <= issue_cmd;
            wd_count <= '0;
         end else if (in_wait) begin
            wd_count <= wd_count + CW'(1);
         end

         case (state)
            ST_RST: idx <= '0;
            ST_INIT_WAIT: begin
               if (spi_done) begin
                  if (idx == LAST_INIT) begin
                     init_done <= 1'b1;
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
            end
            ST_POLL_WAIT: byte_idx <= '0;
            ST_RD_WAIT: begin
               if (spi_done) begin
                  if (byte_idx == LAST_BYTE) begin
                     x_data <= {shadow[1], shadow[0]};
                     y_data <= {shadow[3], shadow[2]};
                     z_data <= {spi_data_rx, shadow[4]};
                  end else begin
                     shadow[byte_idx] <= spi_data_rx;
                     byte_idx         <= byte_idx + 3'd1;
                  end
               end
            end
            default: ;
         endcase

         if (fault_set) begin
            fault     <= 1'b1;
            init_done <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Directed bench for accel_spi_sequencer with a fixed-latency serializer model.
module tb_accel_spi_sequencer;

   localparam int POLL = 10;
   localparam int TMO  = 64;
   localparam int LAT  = 18;

   logic        spi_clk     = 1'b0;
   logic        reset_n     = 1'b1;
   logic        spi_start;
   logic [15:0] spi_data_tx;
   logic        spi_done    = 1'b0;
   logic [7:0]  spi_data_rx = 8'h00;
   logic [15:0] x_data;
   logic [15:0] y_data;
   logic [15:0] z_data;
   logic        data_valid;
   logic        init_done;
   logic        fault;

   accel_spi_sequencer #(
      .POLL_CYCLES    (POLL),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .spi_clk     (spi_clk),
      .reset_n     (reset_n),
      .spi_start   (spi_start),
      .spi_data_tx (spi_data_tx),
      .spi_done    (spi_done),
      .spi_data_rx (spi_data_rx),
      .x_data      (x_data),
      .y_data      (y_data),
      .z_data      (z_data),
      .data_valid  (data_valid),
      .init_done   (init_done),
      .fault       (fault)
   );

   always #5 spi_clk = ~spi_clk;

   int cyc = 0;
   always @(posedge spi_clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   logic [7:0]  rd_bytes [6] = '{8'h01, 8'hFF, 8'h34, 8'h12, 8'h00, 8'h80};
   logic [15:0] exp_rd   [6] = '{16'hB200, 16'hB300, 16'hB400, 16'hB500, 16'hB600, 16'hB700};
   logic [15:0] exp_init [3] = '{16'h3108, 16'h2C0A, 16'h2D08};

   int          lat_cnt   = 0;
   logic [15:0] pend_cmd  = 16'h0000;
   bit          withhold  = 1'b0;
   int          inject_at = -1;

   // Serializer model: done pulses LAT cycles after each observed start.
   always @(negedge spi_clk) begin
      spi_done = 1'b0;
      if (!reset_n) begin
         lat_cnt = 0;
      end else begin
         if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
               spi_done    = 1'b1;
               spi_data_rx = pend_cmd[15] ? rd_bytes[int'(pend_cmd[13:8]) - 'h32] : 8'h00;
            end
         end
         if (cyc == inject_at) begin
            spi_done    = 1'b1;
            spi_data_rx = 8'hEE;
         end
         if (spi_start && !(withhold && spi_data_tx == 16'hB500)) begin
            lat_cnt  = LAT;
            pend_cmd = spi_data_tx;
         end
      end
   end

   logic [15:0] tx_log [$];
   int          start_cyc [$];
   int          dv_count       = 0;
   int          dv_cyc         = -1;
   int          reset_starts   = 0;
   int          init_rise_cyc  = -1;
   int          fault_rise_cyc = -1;
   logic        prev_init      = 1'b0;
   logic        prev_fault     = 1'b0;

   always @(negedge spi_clk) begin
      if (spi_start) begin
         if (!reset_n) reset_starts++;
         tx_log.push_back(spi_data_tx);
         start_cyc.push_back(cyc);
      end
      if (data_valid) begin
         dv_count++;
         dv_cyc = cyc;
      end
      if (init_done && !prev_init) init_rise_cyc = cyc;
      if (fault && !prev_fault) fault_rise_cyc = cyc;
      prev_init  = init_done;
      prev_fault = fault;
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge spi_clk);
         #1;
      end
   endtask

   task automatic apply_stimulus(input logic rst_level);
      @(negedge spi_clk);
      reset_n = rst_level;
   endtask

   function automatic bit cond(input int kind, input int arg);
      case (kind)
         0:       return dv_count >= arg;
         1:       return tx_log.size() >= arg;
         2:       return init_done == 1'b1;
         3:       return fault == 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_cond(input int kind, input int arg, input int limit, input string tag);
      int n = 0;
      while (!cond(kind, arg) && n < limit) begin
         step(1);
         n++;
      end
      check_output(tag, 32'(cond(kind, arg)), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_start"}, 32'(spi_start), 32'd0);
      check_output({tag, "_tx"},    32'(spi_data_tx), 32'h0000);
      check_output({tag, "_x"},     32'(x_data), 32'h0000);
      check_output({tag, "_y"},     32'(y_data), 32'h0000);
      check_output({tag, "_z"},     32'(z_data), 32'h0000);
      check_output({tag, "_dv"},    32'(data_valid), 32'd0);
      check_output({tag, "_init"},  32'(init_done), 32'd0);
      check_output({tag, "_fault"}, 32'(fault), 32'd0);
   endtask

   initial begin
      int rel;
      int t1;
      int t2;
      int s;
      int n;

      #0 reset_n = 1'b0;
      step(3);
      check_reset_outputs("rst");

      apply_stimulus(1'b1);
      rel = cyc;
      wait_cond(1, 1, 10, "first_start_seen");
      check_output("first_start_cyc", 32'(start_cyc[0] - rel), 32'd1);

      wait_cond(2, 0, 200, "init_done_seen");
      for (int i = 0; i < 3; i++) check_output("init_cmd", 32'(tx_log[i]), 32'(exp_init[i]));
      check_output("init_spacing", 32'(start_cyc[2] - start_cyc[1]), 32'd19);
      check_output("init_done_cyc", 32'(init_rise_cyc - start_cyc[2]), 32'd19);
      check_output("start_in_reset", 32'(reset_starts), 32'd0);

      wait_cond(0, 1, 400, "burst1_dv");
      for (int i = 0; i < 6; i++) check_output("rd_cmd", 32'(tx_log[3 + i]), 32'(exp_rd[i]));
      check_output("burst1_x", 32'(x_data), 32'hFF01);
      check_output("burst1_y", 32'(y_data), 32'h1234);
      check_output("burst1_z", 32'(z_data), 32'h8000);
      check_output("dv_cyc", 32'(dv_cyc - start_cyc[8]), 32'd19);
      t1 = dv_cyc;
      step(1);
      check_output("dv_one_cycle", 32'(data_valid), 32'd0);

      wait_cond(1, 10, 50, "poll_start_seen");
      check_output("poll_interval", 32'(start_cyc[9] - t1), 32'(POLL));
      check_output("poll_cmd", 32'(tx_log[9]), 32'hB200);

      wait_cond(0, 2, 400, "burst2_dv");
      t2 = dv_cyc;
      inject_at = t2 + 4;
      wait_cond(1, 16, 50, "spur_start_seen");
      check_output("spur_interval", 32'(start_cyc[15] - t2), 32'(POLL));
      check_output("spur_cmd", 32'(tx_log[15]), 32'hB200);
      check_output("spur_dv_count", 32'(dv_count), 32'd2);

      withhold = 1'b1;
      wait_cond(3, 0, 300, "fault_seen");
      s = start_cyc[18];
      check_output("withheld_cmd", 32'(tx_log[18]), 32'hB500);
      check_output("fault_cyc", 32'(fault_rise_cyc - s), 32'(TMO + 1));
      check_output("fault_init_drop", 32'(init_done), 32'd0);
      withhold = 1'b0;
      wait_cond(1, 20, 20, "reinit_start_seen");
      check_output("reinit_cmd", 32'(tx_log[19]), 32'h3108);
      check_output("reinit_cyc", 32'(start_cyc[19] - fault_rise_cyc), 32'd1);
      check_output("fault_keep_x", 32'(x_data), 32'hFF01);
      check_output("fault_keep_y", 32'(y_data), 32'h1234);
      check_output("fault_keep_z", 32'(z_data), 32'h8000);
      check_output("fault_no_dv", 32'(dv_count), 32'd2);
      wait_cond(2, 0, 200, "reinit_done_seen");
      check_output("fault_sticky", 32'(fault), 32'd1);

      wait_cond(1, 26, 300, "mid_burst_seen");
      check_output("mid_burst_cmd", 32'(tx_log[25]), 32'hB500);
      step(5);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      step(3);
      n = tx_log.size();
      apply_stimulus(1'b1);
      rel = cyc;
      wait_cond(1, n + 1, 10, "restart_seen");
      check_output("restart_cmd", 32'(tx_log[n]), 32'h3108);
      check_output("restart_cyc", 32'(start_cyc[n] - rel), 32'd1);
      check_output("restart_dv_count", 32'(dv_count), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
